// File: rtl/half_add_if.sv
// half_add_if: operand/result stream bundle for the half_add stage.
//
// Parameters:
//   WIDTH      number of 1-bit lanes carried on a, b, s and c
//
// Signals:
//   in_valid   operand pair a/b is valid this cycle        (producer -> stage)
//   in_ready   stage can accept an operand pair this cycle (stage -> producer)
//   a, b       operands, one bit per lane                  (producer -> stage)
//   out_valid  s/c hold a valid result                     (stage -> consumer)
//   out_ready  consumer takes the result this cycle        (consumer -> stage)
//   s, c       per-lane sum and carry                      (stage -> consumer)
//   carry_any  OR of all c bits; only with HALF_ADD_CARRY_ANY_EN defined
//
// Modports:
//   slave      the half_add stage itself
//   master     the environment driving operands and consuming results
interface half_add_if #(
    parameter int unsigned WIDTH = 1
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;
`ifdef HALF_ADD_CARRY_ANY_EN
    logic             carry_any;
`endif

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
`ifdef HALF_ADD_CARRY_ANY_EN
        output carry_any,
`endif
        output in_ready,
        output out_valid,
        output s,
        output c
    );

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
`ifdef HALF_ADD_CARRY_ANY_EN
        input  carry_any,
`endif
        input  in_ready,
        input  out_valid,
        input  s,
        input  c
    );

endinterface

// File: rtl/half_add.sv
// half_add: registered WIDTH-lane half adder behind a valid/ready stream.
//
// Each lane computes s = a ^ b and c = a & b independently; the result is
// registered on the accepting edge, so latency is one cycle and throughput is
// one pair per cycle while the consumer keeps out_ready high. A held result
// can be replaced in the same edge it drains, so no bubble is inserted.
//
// Parameters:
//   WIDTH      number of independent lanes (>= 1); must match the bus WIDTH
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears out_valid, s, c
//   bus        half_add_if.slave: in_valid/in_ready/a/b in,
//              out_valid/out_ready/s/c out
//
// Configuration macro:
//   HALF_ADD_CARRY_ANY_EN  when defined, adds bus.carry_any = |(a & b) of the
//                          accepted pair, registered alongside c.
module half_add #(
    parameter int unsigned WIDTH = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    half_add_if.slave bus
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             in_ready;
    logic             accept;

    // A slot is free when empty or when the held result leaves this cycle.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        s_d         = s_q;
        c_d         = c_q;
        if (accept) begin
            // Operands are only looked at on accept, so junk on a/b while
            // in_valid is low never reaches s/c.
            out_valid_d = 1'b1;
            s_d         = bus.a ^ bus.b;
            c_d         = bus.a & bus.b;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            c_q         <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            c_q         <= c_d;
        end
    end

`ifdef HALF_ADD_CARRY_ANY_EN
    logic carry_any_q, carry_any_d;

    always_comb begin
        carry_any_d = carry_any_q;
        if (accept) begin
            carry_any_d = |(bus.a & bus.b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_any_q <= 1'b0;
        end else begin
            carry_any_q <= carry_any_d;
        end
    end

    assign bus.carry_any = carry_any_q;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.c         = c_q;

endmodule

// File: tb/tb_half_add.sv
// tb_half_add: self-checking bench for half_add.
//
// A WIDTH=1 instance covers reset, the truth table, stall and back-to-back
// streaming; a WIDTH=4 instance covers the multi-lane vectors and a random
// run scored against a queue-based reference model.
module tb_half_add;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] s;
        logic [3:0] c;
        logic       any;
    } vec_t;

    typedef struct {
        logic [3:0] s;
        logic [3:0] c;
        logic       any;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    half_add_if #(.WIDTH(1)) bus1 ();
    half_add_if #(.WIDTH(4)) bus4 ();

    half_add #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    half_add #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive1(input logic v, input logic a, input logic b, input logic r);
        bus1.in_valid  = v;
        bus1.a         = a;
        bus1.b         = b;
        bus1.out_ready = r;
    endtask

    task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b,
                          input logic r);
        bus4.in_valid  = v;
        bus4.a         = a;
        bus4.b         = b;
        bus4.out_ready = r;
    endtask

    task automatic check_any4(input string name, input logic exp);
`ifdef HALF_ADD_CARRY_ANY_EN
        check(name, 32'(bus4.carry_any), 32'(exp));
`endif
    endtask

    task automatic check_any1(input string name, input logic exp);
`ifdef HALF_ADD_CARRY_ANY_EN
        check(name, 32'(bus1.carry_any), 32'(exp));
`endif
    endtask

    vec_t tt[4];
    vec_t w4[2];
    res_t exp_q[$];

    initial begin
        // Truth table for the single-lane instance (bit 0 only).
        tt[0] = '{a: 4'd0, b: 4'd0, s: 4'd0, c: 4'd0, any: 1'b0};
        tt[1] = '{a: 4'd0, b: 4'd1, s: 4'd1, c: 4'd0, any: 1'b0};
        tt[2] = '{a: 4'd1, b: 4'd0, s: 4'd1, c: 4'd0, any: 1'b0};
        tt[3] = '{a: 4'd1, b: 4'd1, s: 4'd0, c: 4'd1, any: 1'b1};
        w4[0] = '{a: 4'b1100, b: 4'b1010, s: 4'b0110, c: 4'b1000, any: 1'b1};
        w4[1] = '{a: 4'b0101, b: 4'b1010, s: 4'b1111, c: 4'b0000, any: 1'b0};

        rst_n = 1'b0;
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        drive4(1'b0, 4'h0, 4'h0, 1'b0);

        // Reset state before any clock edge.
        #2;
        check("rst_valid1", 32'(bus1.out_valid), 32'd0);
        check("rst_s1", 32'(bus1.s), 32'd0);
        check("rst_c1", 32'(bus1.c), 32'd0);
        check("rst_valid4", 32'(bus4.out_valid), 32'd0);
        check_any1("rst_any1", 1'b0);

        // Release reset and offer data right away: the first edge accepts it.
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive1(1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("rel_valid", 32'(bus1.out_valid), 32'd1);
        check("rel_s", 32'(bus1.s), 32'd1);
        check("rel_c", 32'(bus1.c), 32'd0);
        drive1(1'b0, 1'b0, 1'b0, 1'b1);

        // Truth table, one pair every 100 ns.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive1(1'b1, tt[i].a[0], tt[i].b[0], 1'b1);
            @(negedge clk);
            check($sformatf("tt%0d_valid", i), 32'(bus1.out_valid), 32'd1);
            check($sformatf("tt%0d_s", i), 32'(bus1.s), 32'(tt[i].s[0]));
            check($sformatf("tt%0d_c", i), 32'(bus1.c), 32'(tt[i].c[0]));
            check_any1($sformatf("tt%0d_any", i), tt[i].any);
            drive1(1'b0, 1'b0, 1'b0, 1'b1);
            repeat (8) @(negedge clk);
            check($sformatf("tt%0d_drained", i), 32'(bus1.out_valid), 32'd0);
        end

        // Stall: 1+1 accepted with the consumer blocked, then 0+1 waits.
        @(negedge clk);
        drive1(1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("stall_valid", 32'(bus1.out_valid), 32'd1);
        check("stall_ready0", 32'(bus1.in_ready), 32'd0);
        drive1(1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("stall_s_hold", 32'(bus1.s), 32'd0);
        check("stall_c_hold", 32'(bus1.c), 32'd1);
        check_any1("stall_any_hold", 1'b1);
        check("stall_ready1", 32'(bus1.in_ready), 32'd0);
        check("stall_valid_hold", 32'(bus1.out_valid), 32'd1);
        bus1.out_ready = 1'b1;
        #1;
        check("stall_ready_comb", 32'(bus1.in_ready), 32'd1);
        // Drain and accept share this edge.
        @(negedge clk);
        check("stall_new_valid", 32'(bus1.out_valid), 32'd1);
        check("stall_new_s", 32'(bus1.s), 32'd1);
        check("stall_new_c", 32'(bus1.c), 32'd0);
        drive1(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("stall_drained", 32'(bus1.out_valid), 32'd0);

        // Back-to-back: four pairs on consecutive edges.
        drive1(1'b1, tt[0].a[0], tt[0].b[0], 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("b2b%0d_valid", i - 1), 32'(bus1.out_valid), 32'd1);
            check($sformatf("b2b%0d_s", i - 1), 32'(bus1.s), 32'(tt[i-1].s[0]));
            check($sformatf("b2b%0d_c", i - 1), 32'(bus1.c), 32'(tt[i-1].c[0]));
            if (i < 4) drive1(1'b1, tt[i].a[0], tt[i].b[0], 1'b1);
            else       drive1(1'b0, 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk);
        check("b2b_end", 32'(bus1.out_valid), 32'd0);

        // Asynchronous reset mid-cycle discards a held result.
        drive1(1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        check("arst_pre_valid", 32'(bus1.out_valid), 32'd1);
        check("arst_pre_c", 32'(bus1.c), 32'd1);
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus1.out_valid), 32'd0);
        check("arst_s", 32'(bus1.s), 32'd0);
        check("arst_c", 32'(bus1.c), 32'd0);
        check_any1("arst_any", 1'b0);
        @(posedge clk);
        #1;
        check("arst_hold_valid", 32'(bus1.out_valid), 32'd0);
        check("arst_hold_c", 32'(bus1.c), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Multi-lane vectors.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive4(1'b1, w4[i].a, w4[i].b, 1'b1);
            @(negedge clk);
            check($sformatf("w4_%0d_valid", i), 32'(bus4.out_valid), 32'd1);
            check($sformatf("w4_%0d_s", i), 32'(bus4.s), 32'(w4[i].s));
            check($sformatf("w4_%0d_c", i), 32'(bus4.c), 32'(w4[i].c));
            check_any4($sformatf("w4_%0d_any", i), w4[i].any);
            drive4(1'b0, 4'h0, 4'h0, 1'b1);
        end
        @(negedge clk);
        check("w4_drained", 32'(bus4.out_valid), 32'd0);

        // Random traffic against a queue of pending results (holds at most one).
        exp_q.delete();
        for (int n = 0; n < 400; n++) begin
            logic       v, r, acc;
            logic [3:0] ra, rb;
            @(negedge clk);
            check("rnd_valid", 32'(bus4.out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("rnd_s", 32'(bus4.s), 32'(exp_q[0].s));
                check("rnd_c", 32'(bus4.c), 32'(exp_q[0].c));
                check_any4("rnd_any", exp_q[0].any);
            end
            v  = 1'($urandom_range(0, 1));
            r  = ($urandom_range(0, 3) != 0);
            ra = 4'($urandom);
            rb = 4'($urandom);
            drive4(v, ra, rb, r);
            #1;
            check("rnd_in_ready", 32'(bus4.in_ready), 32'(exp_q.size() == 0 || r));
            @(posedge clk);
            acc = v && (exp_q.size() == 0 || r);
            if (exp_q.size() != 0 && r) void'(exp_q.pop_front());
            if (acc) begin
                res_t e;
                e.s   = ra ^ rb;
                e.c   = ra & rb;
                e.any = (e.c != 4'd0);
                exp_q.push_back(e);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
